spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_controller.sv | 141 ++++++++++++++
 tb/tb_spi_controller.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 controller that sends and receives one byte per request. cs_n stays low for 18*CLKS_PER_HALF_BIT cycles, then o_rx_dv pulses and o_tx_ready rises in the same cycle.
// A request is taken only while o_tx_ready is high; nothing is queued. Defining SPI_CONTROLLER_DEBUG_EN adds the o_debug_state and o_debug_bit_index ports.
module spi_controller #(
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_dv,
  output logic       o_tx_ready,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_dv,
  output logic       o_spi_clk,
  output logic       o_spi_copi,
  input  logic       i_spi_cipo,
  output logic       o_spi_cs_n
`ifdef SPI_CONTROLLER_DEBUG_EN
  ,
  output logic [1:0] o_debug_state,
  output logic [2:0] o_debug_bit_index
`endif
);

  localparam int HALF_W = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam logic [HALF_W-1:0] HALF_MAX = HALF_W'(CLKS_PER_HALF_BIT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CS_SETUP = 2'd1,
    TRANSFER = 2'd2,
    CS_HOLD  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [HALF_W-1:0] r_half_cnt;
  logic [4:0]        r_edge_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_tx_byte;
  logic [7:0]        r_rx_shift;
  logic [7:0]        r_rx_byte;
  logic              r_rx_dv;
  logic              r_spi_clk;
  logic              w_half_last;
  logic              w_last_edge;
  logic              w_accept;
  logic              w_done;

  assign w_half_last = (r_half_cnt == HALF_MAX);
  assign w_last_edge = (r_edge_cnt == 5'd15);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_tx_dv) begin
          w_next_state = CS_SETUP;
          w_accept     = 1'b1;
        end
      end
      CS_SETUP: begin
        if (w_half_last) begin
          w_next_state = TRANSFER;
        end
      end
      TRANSFER: begin
        // The 16th SCLK edge (a falling one) coincides with the move to CS_HOLD.
        if (w_half_last && w_last_edge) begin
          w_next_state = CS_HOLD;
        end
      end
      CS_HOLD: begin
        if (w_half_last) begin
          w_next_state = IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_half_cnt <= '0;
      r_edge_cnt <= '0;
      r_bit_idx  <= '0;
      r_tx_byte  <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_rx_dv    <= 1'b0;
      r_spi_clk  <= 1'b0;
    end else begin
      r_rx_dv <= w_done;
      if (w_accept) begin
        r_tx_byte  <= i_tx_byte;
        r_bit_idx  <= 3'd7;
        r_rx_shift <= '0;
        r_half_cnt <= '0;
        r_edge_cnt <= '0;
        r_spi_clk  <= 1'b0;
      end else if (r_state != IDLE) begin
        r_half_cnt <= w_half_last ? '0 : r_half_cnt + HALF_W'(1);
        if (r_state == TRANSFER && w_half_last) begin
          r_spi_clk  <= ~r_spi_clk;
          r_edge_cnt <= r_edge_cnt + 5'd1;
          if (!r_spi_clk) begin
            r_rx_shift <= {r_rx_shift[6:0], i_spi_cipo};
          end else if (!w_last_edge) begin
            r_bit_idx <= r_bit_idx - 3'd1;
          end
        end
      end
      if (w_done) begin
        r_rx_byte <= r_rx_shift;
      end
    end
  end

  assign o_tx_ready = (r_state == IDLE);
  assign o_spi_cs_n = (r_state == IDLE);
  assign o_spi_clk  = r_spi_clk;
  assign o_spi_copi = (r_state != IDLE) ? r_tx_byte[r_bit_idx] : 1'b0;
  assign o_rx_byte  = r_rx_byte;
  assign o_rx_dv    = r_rx_dv;

`ifdef SPI_CONTROLLER_DEBUG_EN
  assign o_debug_state     = r_state;
  assign o_debug_bit_index = r_bit_idx;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench: three controllers with half-bit periods of 2, 1 and 3 clocks, a mode-0 peripheral model on the N=3 instance.
module tb_spi_controller;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic       rst2, tx_dv2, tx_ready2, rx_dv2, spi_clk2, copi2, cipo2, cs_n2;
  logic [7:0] tx_byte2, rx_byte2;
  logic       rst1, tx_dv1, tx_ready1, rx_dv1, spi_clk1, copi1, cipo1, cs_n1;
  logic [7:0] tx_byte1, rx_byte1;
  logic       rst3, tx_dv3, tx_ready3, rx_dv3, spi_clk3, copi3, cipo3, cs_n3;
  logic [7:0] tx_byte3, rx_byte3;
`ifdef SPI_CONTROLLER_DEBUG_EN
  logic [1:0] dbg_state1, dbg_state2, dbg_state3;
  logic [2:0] dbg_idx1, dbg_idx2, dbg_idx3;
`endif

  assign cipo2 = copi2;
  assign cipo1 = 1'b0;

  spi_controller #(.CLKS_PER_HALF_BIT(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst2), .i_tx_byte(tx_byte2), .i_tx_dv(tx_dv2),
    .o_tx_ready(tx_ready2), .o_rx_byte(rx_byte2), .o_rx_dv(rx_dv2),
    .o_spi_clk(spi_clk2), .o_spi_copi(copi2), .i_spi_cipo(cipo2), .o_spi_cs_n(cs_n2)
`ifdef SPI_CONTROLLER_DEBUG_EN
    , .o_debug_state(dbg_state2), .o_debug_bit_index(dbg_idx2)
`endif
  );

  spi_controller #(.CLKS_PER_HALF_BIT(1)) u_dut1 (
    .i_clk(clk), .i_reset(rst1), .i_tx_byte(tx_byte1), .i_tx_dv(tx_dv1),
    .o_tx_ready(tx_ready1), .o_rx_byte(rx_byte1), .o_rx_dv(rx_dv1),
    .o_spi_clk(spi_clk1), .o_spi_copi(copi1), .i_spi_cipo(cipo1), .o_spi_cs_n(cs_n1)
`ifdef SPI_CONTROLLER_DEBUG_EN
    , .o_debug_state(dbg_state1), .o_debug_bit_index(dbg_idx1)
`endif
  );

  spi_controller #(.CLKS_PER_HALF_BIT(3)) u_dut3 (
    .i_clk(clk), .i_reset(rst3), .i_tx_byte(tx_byte3), .i_tx_dv(tx_dv3),
    .o_tx_ready(tx_ready3), .o_rx_byte(rx_byte3), .o_rx_dv(rx_dv3),
    .o_spi_clk(spi_clk3), .o_spi_copi(copi3), .i_spi_cipo(cipo3), .o_spi_cs_n(cs_n3)
`ifdef SPI_CONTROLLER_DEBUG_EN
    , .o_debug_state(dbg_state3), .o_debug_bit_index(dbg_idx3)
`endif
  );

  // Event counters, sampled on the falling clock edge while DUT outputs are stable.
  int   cs_low2 = 0, rise2 = 0, rxdv_cnt2 = 0;
  int   rise1 = 0, copi_hi1 = 0, rxdv_cnt1 = 0;
  int   rise3 = 0;
  logic prev_clk1 = 1'b0, prev_clk2 = 1'b0, prev_clk3 = 1'b0, prev_cs3 = 1'b1;
  logic [7:0] p_pat = 8'h3C;
  logic [7:0] p_rx  = 8'h00;
  int   p_idx = 7;

  always @(negedge clk) begin
    if (cs_n2 === 1'b0) cs_low2++;
    if (rx_dv2 === 1'b1) rxdv_cnt2++;
    if (spi_clk2 === 1'b1 && prev_clk2 === 1'b0) rise2++;
    prev_clk2 = spi_clk2;
    if (rx_dv1 === 1'b1) rxdv_cnt1++;
    if (spi_clk1 === 1'b1 && prev_clk1 === 1'b0) begin
      rise1++;
      if (copi1 === 1'b1) copi_hi1++;
    end
    prev_clk1 = spi_clk1;
  end

  // Mode-0 peripheral: presents MSB on cs_n fall, samples COPI on SCLK rise, shifts on SCLK fall.
  always @(negedge clk) begin
    if (cs_n3 !== 1'b0) begin
      p_idx = 7;
      cipo3 = p_pat[7];
    end else begin
      if (prev_cs3 === 1'b1) p_rx = 8'h00;
      if (spi_clk3 === 1'b1 && prev_clk3 === 1'b0) begin
        p_rx = {p_rx[6:0], copi3};
        rise3++;
      end
      if (spi_clk3 === 1'b0 && prev_clk3 === 1'b1 && p_idx > 0) begin
        p_idx--;
        cipo3 = p_pat[p_idx];
      end
    end
    prev_clk3 = spi_clk3;
    prev_cs3  = cs_n3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int b_cs, b_rise, b_dv, b_dv1, b_rise1, b_hi1, b_rise3;
`ifdef SPI_CONTROLLER_DEBUG_EN
    logic [7:0] slog;
    logic [1:0] last_st;
    logic [2:0] last_idx;
    int         decs;
`endif
    rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
    tx_dv1 = 1'b0; tx_dv2 = 1'b0; tx_dv3 = 1'b0;
    tx_byte1 = 8'h00; tx_byte2 = 8'h00; tx_byte3 = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n2, 1);
    chk("rst_spi_clk", spi_clk2, 0);
    chk("rst_copi", copi2, 0);
    chk("rst_tx_ready", tx_ready2, 1);
    chk("rst_rx_dv", rx_dv2, 0);
    chk("rst_rx_byte", rx_byte2, 8'h00);
    rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    repeat (2) @(negedge clk);

    // Loopback 0xA5, N=2
    b_cs = cs_low2; b_rise = rise2; b_dv = rxdv_cnt2;
    tx_byte2 = 8'hA5; tx_dv2 = 1'b1;
    @(negedge clk); tx_dv2 = 1'b0;
    chk("A_cs_n_low", cs_n2, 0);
    chk("A_tx_ready_low", tx_ready2, 0);
    chk("A_copi_msb", copi2, 1);
    n = 0;
    while (rx_dv2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("A_latency", n, 36);
    chk("A_rx_byte", rx_byte2, 8'hA5);
    chk("A_cs_n_idle", cs_n2, 1);
    chk("A_tx_ready_idle", tx_ready2, 1);
    @(negedge clk);
    chk("A_rx_dv_single", rx_dv2, 0);
    chk("A_rx_byte_held", rx_byte2, 8'hA5);
    repeat (4) @(negedge clk);
    chk("A_cs_low_cycles", cs_low2 - b_cs, 36);
    chk("A_sclk_rises", rise2 - b_rise, 8);
    chk("A_rx_dv_count", rxdv_cnt2 - b_dv, 1);

    // CIPO tied low, 0xFF, N=1
    b_dv1 = rxdv_cnt1; b_rise1 = rise1; b_hi1 = copi_hi1;
    tx_byte1 = 8'hFF; tx_dv1 = 1'b1;
    @(negedge clk); tx_dv1 = 1'b0;
    n = 0;
    while (rx_dv1 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("B_latency", n, 18);
    chk("B_rx_byte", rx_byte1, 8'h00);
    repeat (3) @(negedge clk);
    chk("B_sclk_rises", rise1 - b_rise1, 8);
    chk("B_copi_high_at_rise", copi_hi1 - b_hi1, 8);
    chk("B_rx_dv_count", rxdv_cnt1 - b_dv1, 1);

    // Peripheral model returns 0x3C while receiving 0xC3, N=3
    b_rise3 = rise3;
    tx_byte3 = 8'hC3; tx_dv3 = 1'b1;
    @(negedge clk); tx_dv3 = 1'b0;
    n = 0;
    while (rx_dv3 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("C_latency", n, 54);
    chk("C_rx_byte", rx_byte3, 8'h3C);
    chk("C_periph_rx", p_rx, 8'hC3);
    chk("C_sclk_rises", rise3 - b_rise3, 8);

    // Back-to-back with i_tx_dv held high, then a strobe while busy
    b_cs = cs_low2; b_dv = rxdv_cnt2;
    tx_byte2 = 8'h11; tx_dv2 = 1'b1;
    @(negedge clk); tx_byte2 = 8'h22;
    chk("D_first_cs_n", cs_n2, 0);
    n = 0;
    while (rx_dv2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("D_latency1", n, 36);
    chk("D_rx_byte1", rx_byte2, 8'h11);
    chk("D_gap_cs_n_high", cs_n2, 1);
    @(negedge clk);
    chk("D_second_cs_n", cs_n2, 0);
    chk("D_second_copi_msb", copi2, 0);
    chk("D_second_ready", tx_ready2, 0);
    tx_dv2 = 1'b0;
    repeat (6) @(negedge clk);
    tx_byte2 = 8'h77; tx_dv2 = 1'b1;
    @(negedge clk); tx_dv2 = 1'b0;
    n = 0;
    while (rx_dv2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("D_latency2", n, 29);
    chk("D_rx_byte2", rx_byte2, 8'h22);
    repeat (50) @(negedge clk);
    chk("D_no_queue_cs_n", cs_n2, 1);
    chk("D_rx_dv_count", rxdv_cnt2 - b_dv, 2);
    chk("D_cs_low_cycles", cs_low2 - b_cs, 72);

    // Reset during the 4th bit, with a request presented under reset
    b_dv = rxdv_cnt2;
    tx_byte2 = 8'hE8; tx_dv2 = 1'b1;
    @(negedge clk); tx_dv2 = 1'b0;
    repeat (16) @(negedge clk);
    chk("E_copi_bit4", copi2, 0);
    chk("E_cs_n_busy", cs_n2, 0);
    rst2 = 1'b1; tx_byte2 = 8'h99; tx_dv2 = 1'b1;
    @(negedge clk);
    chk("E_rst_cs_n", cs_n2, 1);
    chk("E_rst_spi_clk", spi_clk2, 0);
    chk("E_rst_copi", copi2, 0);
    chk("E_rst_ready", tx_ready2, 1);
    chk("E_rst_rx_dv", rx_dv2, 0);
    chk("E_rst_rx_byte", rx_byte2, 8'h00);
    rst2 = 1'b0; tx_dv2 = 1'b0;
    repeat (40) @(negedge clk);
    chk("E_no_rx_dv", rxdv_cnt2 - b_dv, 0);
    chk("E_dv_in_reset_ignored", cs_n2, 1);
    tx_byte2 = 8'h5A; tx_dv2 = 1'b1;
    @(negedge clk); tx_dv2 = 1'b0;
    n = 0;
    while (rx_dv2 !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("E_latency", n, 36);
    chk("E_rx_byte", rx_byte2, 8'h5A);

`ifdef SPI_CONTROLLER_DEBUG_EN
    repeat (3) @(negedge clk);
    chk("F_dbg_idle_state", dbg_state2, 0);
    tx_byte2 = 8'h80; tx_dv2 = 1'b1;
    @(negedge clk); tx_dv2 = 1'b0;
    chk("F_dbg_setup_state", dbg_state2, 1);
    chk("F_dbg_start_idx", dbg_idx2, 7);
    slog = 8'h01; last_st = 2'd1; last_idx = 3'd7; decs = 0;
    n = 0;
    while (rx_dv2 !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
      if (dbg_state2 != last_st) begin slog = {slog[5:0], dbg_state2}; last_st = dbg_state2; end
      if (dbg_idx2 != last_idx) begin
        if (dbg_idx2 == 3'(last_idx - 3'd1)) decs++;
        last_idx = dbg_idx2;
      end
    end
    chk("F_state_sequence", slog, 8'h6C);
    chk("F_idx_decrements", decs, 7);
    chk("F_idx_final", dbg_idx2, 0);
    chk("F_rx_byte", rx_byte2, 8'h80);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
